// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: state encoding, direction codes
// and the datapath width.
package shift_sequencer_pkg;

  localparam int DATA_W = 8;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/comb_shifter.sv
// Single-pass logical shifter, zero fill; n is limited to 0..7 by its width.
module comb_shifter
  import shift_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [2:0]        n,
  input  logic              dir,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = (dir == DIR_LEFT) ? (a << n) : (a >> n);
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: splits an arbitrary shift amount into passes of at
// most STEP_MAX through comb_shifter and returns the result on a valid/ready port.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int STEP_MAX = 7,
  parameter int AMT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_steps,
  output logic              out_zero
);

  state_t              state;
  state_t              state_next;
  logic [AMT_W-1:0]    remaining;
  logic [AMT_W-1:0]    remaining_next;
  logic [DATA_W-1:0]   data;
  logic [DATA_W-1:0]   shifted;
  logic                dir;
  logic [5:0]          steps;
  logic [2:0]          step;

  comb_shifter u_shifter (
    .a   (data),
    .n   (step),
    .dir (dir),
    .y   (shifted)
  );

  // Clamp each pass to STEP_MAX; step never exceeds remaining, so no underflow.
  always_comb begin
    step = remaining[2:0];
    if (remaining > AMT_W'(STEP_MAX)) begin
      step = 3'(STEP_MAX);
    end
    remaining_next = remaining - {{(AMT_W-3){1'b0}}, step};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = (in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (remaining_next == '0 || shifted == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      data      <= '0;
      dir       <= DIR_RIGHT;
      steps     <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        remaining <= in_amt;
        data      <= in_data;
        dir       <= in_dir;
        steps     <= '0;
      end else if (state == SHIFT) begin
        remaining <= remaining_next;
        data      <= shifted;
        // Pass count saturates rather than wrapping for tiny STEP_MAX.
        if (steps != 6'd63) begin
          steps <= steps + 6'd1;
        end
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = data;
  assign out_steps = steps;
  assign out_zero  = (state == DONE) && (data == '0);

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift engine that sits directly upstream of comb_shifter and drives it. Accepts a byte plus an arbitrary 8-bit shift amount over a valid/ready handshake.
- Splits the amount into per-cycle chunks of at most STEP_MAX, which comb_shifter can apply in one pass. Iterates the byte through the shifter, then presents the registered result on a valid/ready output.
- Also reports the number of shift passes used and a zero-result flag.

Parameters:
- STEP_MAX, 7, largest amount applied per SHIFT cycle; legal range 1..7.
- AMT_W, 8, width of the requested shift amount.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  engine can accept a request.
- in_data  input  8  byte to shift.
- in_amt  input  AMT_W  total shift amount.
- in_dir  input  1  0 = right, 1 = left (same encoding as comb_shifter dir).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  8  shifted byte.
- out_steps  output  6  number of SHIFT passes performed.
- out_zero  output  1  out_data == 0.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset, effective immediately on rst_n low:
  - state = IDLE.
  - in_ready = 1 (combinational from IDLE).
  - out_valid = 0, out_data = 0, out_steps = 0, out_zero = 0.
  - Internal remaining-amount, data and step registers = 0.
- Shift semantics: logical, zero fill.
  - Right (dir=0): Y = A >> n. Left (dir=1): Y = A << n.
  - The internal comb_shifter instance only ever sees n in 0..STEP_MAX.
- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE:
  - On in_valid && in_ready: latch in_data, in_amt and in_dir; clear the step counter.
  - If in_amt == 0, go to DONE. Otherwise go to SHIFT.
- SHIFT, once per cycle:
  - step = min(remaining, STEP_MAX).
  - data <= shifter(data, step, dir); remaining <= remaining - step; steps <= steps + 1.
  - Go to DONE when the new remaining == 0 OR the new data == 0. The zero case is an early exit: further shifting cannot change the result.
  - Otherwise stay in SHIFT.
- DONE:
  - Hold out_data, out_steps and out_zero stable while out_valid && !out_ready.
  - On out_ready, go to IDLE the next cycle.
  - No request is accepted in the DONE cycle, so throughput is one request per k+2 cycles.
- Latency, with request accepted at edge T and k = passes performed:
  - out_valid rises after edge T+k+1.
  - amt = 0 gives k = 0 and a result after T+1.
  - Without early exit, k = ceil(amt / STEP_MAX).
- Arithmetic: remaining is AMT_W bits and never underflows, because step <= remaining by construction. out_steps max is 255 at STEP_MAX=1, which saturates at 63.
- Boundaries:
  - in_valid while busy: ignored (in_ready = 0). The requester must hold its request.
  - out_ready high before out_valid: no effect.
  - in_data == 0 with amt > 0: one SHIFT pass, then early exit with out_steps = 1, out_zero = 1.
  - rst_n asserted mid-SHIFT or in DONE: the in-flight result is discarded with no output handshake, and the engine returns to IDLE.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1.
  - data width constant 8.
- Sub-module: comb_shifter, instantiated unmodified as the datapath. Only the FSM, counters and handshake live in shift_sequencer.

Test Plan:
- Zero amount: in_data=8'h81, in_amt=0, dir=0 accepted at T → out_valid after T+1, out_data=8'h81, out_steps=0, out_zero=0.
- Single pass: 8'h81, amt=3, dir=1 → out_data=8'h08, out_steps=1, out_valid after T+2.
- Multi-pass, STEP_MAX=1: 8'h81, amt=5, dir=0 → 8'h04, out_steps=5, and in_ready stays low for the whole operation.
- Early exit: 8'h01, amt=255, dir=1, STEP_MAX=7 → passes give 8'h80, then 8'h00 → out_data=0, out_steps=2, out_zero=1.
- Backpressure: hold out_ready=0 for 4 cycles in DONE → outputs stable and in_valid ignored; out_ready=1 → IDLE next cycle, and a new request is accepted.
- Reset mid-op: STEP_MAX=1, amt=6, pulse rst_n low in the third SHIFT cycle → immediately out_valid=0 and out_data=0; after release in_ready=1, and no stale result ever appears.
